// File: rtl/ym_bus_writer.sv
// Queues FM synth register writes and replays each as a timed address cycle and a timed data
// cycle on the chip-select/A1-A0/data/wr_n bus, with the chip's busy wait after each cycle.
module ym_bus_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int SETUP      = 2,
    parameter int WR_PULSE   = 4,
    parameter int HOLD       = 2,
    parameter int ADDR_WAIT  = 102,
    parameter int DATA_WAIT  = 498
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [4:0]                    cmd_chip,
    input  logic                          cmd_port,
    input  logic [7:0]                    cmd_reg,
    input  logic [7:0]                    cmd_data,
    output logic [4:0]                    cs,
    output logic [1:0]                    addr,
    output logic [7:0]                    bus_dout,
    output logic                          wr_n,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          drop,
    output logic [3:0]                    dbg_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] SETUP_C = CNT_W'(SETUP - 1);
    localparam logic [CNT_W-1:0] PULSE_C = CNT_W'(WR_PULSE - 1);
    localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] AWAIT_C = (ADDR_WAIT == 0) ? '0 : CNT_W'(ADDR_WAIT - 1);
    localparam logic [CNT_W-1:0] DWAIT_C = (DATA_WAIT == 0) ? '0 : CNT_W'(DATA_WAIT - 1);
    localparam logic [PTR_W:0]   FULL_LVL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [3:0] {
        IDLE, A_SETUP, A_STROBE, A_HOLD, A_WAIT, D_SETUP, D_STROBE, D_HOLD, D_WAIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [21:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [21:0]      head;
    logic [4:0]       w_chip;
    logic             w_port;
    logic [7:0]       w_reg;
    logic [7:0]       w_data;
    logic             push;
    logic             pop;
    logic             empty;
    logic             cmd_done;
    logic [PTR_W:0]   level_nxt;

    assign head      = mem[rd_ptr];
    assign empty     = (fifo_level == '0);
    assign push      = cmd_valid && cmd_ready;
    // Last cycle of a command: the next head can be popped straight into A_SETUP.
    assign cmd_done  = (cnt == '0) &&
                       ((state == D_WAIT) || ((state == D_HOLD) && (DATA_WAIT == 0)));
    assign pop       = !empty && ((state == IDLE) || cmd_done);
    assign level_nxt = fifo_level + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_chip, cmd_port, cmd_reg, cmd_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            cmd_ready  <= 1'b1;
            w_chip     <= '0;
            w_port     <= 1'b0;
            w_reg      <= '0;
            w_data     <= '0;
            cs         <= '0;
            addr       <= '0;
            bus_dout   <= '0;
            wr_n       <= 1'b1;
            busy       <= 1'b0;
            drop       <= 1'b0;
        end else begin
            drop       <= 1'b0;
            fifo_level <= level_nxt;
            cmd_ready  <= (level_nxt != FULL_LVL);
            busy       <= (state != IDLE) || !empty;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                {w_chip, w_port, w_reg, w_data} <= head;
            end

            // Bus pins follow the state one cycle later, so every phase keeps its length.
            case (state)
                A_SETUP, A_STROBE, A_HOLD: begin
                    cs       <= w_chip;
                    addr     <= {w_port, 1'b0};
                    bus_dout <= w_reg;
                    wr_n     <= (state != A_STROBE);
                end
                D_SETUP, D_STROBE, D_HOLD: begin
                    cs       <= w_chip;
                    addr     <= {w_port, 1'b1};
                    bus_dout <= w_data;
                    wr_n     <= (state != D_STROBE);
                end
                default: begin
                    cs       <= '0;
                    addr     <= '0;
                    bus_dout <= '0;
                    wr_n     <= 1'b1;
                end
            endcase

            if ((state == IDLE) || cmd_done) begin
                if (pop && (head[21:17] != 5'd0)) begin
                    state <= A_SETUP;
                    cnt   <= SETUP_C;
                end else begin
                    state <= IDLE;
                    drop  <= pop;
                end
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                case (state)
                    A_SETUP:  begin state <= A_STROBE; cnt <= PULSE_C; end
                    A_STROBE: begin state <= A_HOLD;   cnt <= HOLD_C;  end
                    A_HOLD: begin
                        if (ADDR_WAIT != 0) begin
                            state <= A_WAIT;
                            cnt   <= AWAIT_C;
                        end else begin
                            state <= D_SETUP;
                            cnt   <= SETUP_C;
                        end
                    end
                    A_WAIT:   begin state <= D_SETUP;  cnt <= SETUP_C; end
                    D_SETUP:  begin state <= D_STROBE; cnt <= PULSE_C; end
                    D_STROBE: begin state <= D_HOLD;   cnt <= HOLD_C;  end
                    D_HOLD:   begin state <= D_WAIT;   cnt <= DWAIT_C; end
                    default:  begin state <= IDLE;     cnt <= '0;      end
                endcase
            end
        end
    end

endmodule
